// File: rtl/gate_model_bist.sv
// LFSR pattern source and MISR response compactor around a 13-in/10-out gate model,
// sequenced by a small IDLE/RUN/DONE controller that reports a golden-signature pass/fail.
module gate_model_bist #(
  parameter int unsigned PATTERNS = 256,
  parameter logic [12:0] SEED     = 13'h0001,
  parameter logic [9:0]  GOLDEN   = 10'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [12:0] pat,
  input  logic [9:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [9:0]  sig,
  output logic [12:0] pat_cnt
);

  localparam int unsigned PW = 13;
  localparam int unsigned RW = 10;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [PW-1:0] SEED_EFF = (SEED == '0) ? PW'(1) : SEED;
  localparam logic [PW-1:0] LAST     = PW'(PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   load;
  logic   adv;
  logic   fin;
  logic [RW-1:0] misr_nxt;

  // Fibonacci LFSR, x^13+x^4+x^3+x+1
  function automatic logic [PW-1:0] lfsr_next(input logic [PW-1:0] l);
    logic fb;
    fb = l[12] ^ l[3] ^ l[2] ^ l[0];
    return {l[PW-2:0], fb};
  endfunction

  // Galois MISR, x^10+x^3+1
  function automatic logic [RW-1:0] misr_step(input logic [RW-1:0] m,
                                               input logic [RW-1:0] r);
    logic [RW-1:0] n;
    logic          f;
    f    = m[RW-1];
    n    = {m[RW-2:0], 1'b0} ^ r;
    n[0] = n[0] ^ f;
    n[3] = n[3] ^ f;
    return n;
  endfunction

  assign misr_nxt = misr_step(sig, resp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes; abort wins over everything.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          adv = 1'b1;
          if (pat_cnt == LAST) begin
            fin       = 1'b1;
            state_nxt = DONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat     <= '0;
      sig     <= '0;
      pat_cnt <= '0;
      pass    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (abort) begin
        pass <= 1'b0;
      end else if (load) begin
        pat     <= SEED_EFF;
        sig     <= '0;
        pat_cnt <= '0;
        pass    <= 1'b0;
      end else if (adv) begin
        sig     <= misr_nxt;
        pat_cnt <= pat_cnt + PW'(1);
        // The last pattern stays on pat so DONE shows what was applied.
        if (fin) begin
          pass <= (misr_nxt == GOLDEN);
        end else begin
          pat <= lfsr_next(pat);
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_model_bist.sv
// Randomized bench for gate_model_bist: several parameterizations run against a
// polynomial-arithmetic reference of the pattern generator and signature compactor.
module tb_gate_model_bist;

  logic        clk;
  logic        rst_n;
  logic [4:0]  start;
  logic [4:0]  abort;
  logic [9:0]  rsp [4];
  logic [9:0]  gm_resp;
  logic [12:0] pat [5];
  logic [9:0]  sig [5];
  logic [12:0] pat_cnt [5];
  logic        busy [5];
  logic        done [5];
  logic        pass [5];

  int n_checks = 0;
  int n_errors = 0;
  logic [12:0] pat_log [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gate_model_bist #(.PATTERNS(4), .SEED(13'h0001), .GOLDEN(10'h000)) u_p4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .pat(pat[0]),
    .resp(rsp[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .sig(sig[0]),
    .pat_cnt(pat_cnt[0]));

  gate_model_bist #(.PATTERNS(2), .SEED(13'h0001), .GOLDEN(10'h008)) u_p2_g8 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .pat(pat[1]),
    .resp(rsp[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .sig(sig[1]),
    .pat_cnt(pat_cnt[1]));

  gate_model_bist #(.PATTERNS(2), .SEED(13'h0001), .GOLDEN(10'h000)) u_p2_g0 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .pat(pat[2]),
    .resp(rsp[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .sig(sig[2]),
    .pat_cnt(pat_cnt[2]));

  gate_model_bist #(.PATTERNS(1), .SEED(13'h0000), .GOLDEN(10'h000)) u_p1_s0 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort[3]), .pat(pat[3]),
    .resp(rsp[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]), .sig(sig[3]),
    .pat_cnt(pat_cnt[3]));

  gate_model_bist #(.PATTERNS(256), .SEED(13'h0ACE), .GOLDEN(10'h000)) u_gate (
    .clk(clk), .rst_n(rst_n), .start(start[4]), .abort(abort[4]), .pat(pat[4]),
    .resp(gm_resp), .busy(busy[4]), .done(done[4]), .pass(pass[4]), .sig(sig[4]),
    .pat_cnt(pat_cnt[4]));

  function automatic logic [12:0] seed_of(input int k);
    case (k)
      3:       return 13'h0000;
      4:       return 13'h0ACE;
      default: return 13'h0001;
    endcase
  endfunction

  function automatic int pats_of(input int k);
    case (k)
      0:       return 4;
      1, 2:    return 2;
      3:       return 1;
      default: return 256;
    endcase
  endfunction

  function automatic logic [9:0] gold_of(input int k);
    return (k == 1) ? 10'h008 : 10'h000;
  endfunction

  // Stand-in combinational 13-in/10-out gate model.
  function automatic logic [9:0] gate_fn(input logic [12:0] p);
    logic [9:0]  g;
    logic [12:0] mk;
    for (int i = 0; i < 10; i++) begin
      mk   = 13'h0A7 << (i % 6);
      g[i] = (^(p & mk)) ^ (p[i] & p[(i + 4) % 13]) ^ p[12 - i];
    end
    return g;
  endfunction

  always_comb gm_resp = gate_fn(pat[4]);

  // Signature update as polynomial arithmetic: m*x mod (x^10+x^3+1), plus r.
  function automatic logic [9:0] ref_misr(input logic [9:0] m, input logic [9:0] r);
    logic [10:0] t;
    t = 11'(m) << 1;
    if (t >= 11'h400) t = t ^ 11'h409;
    return 10'(t) ^ r;
  endfunction

  // Next pattern: shift left, feed in parity of the tapped bits 12,3,2,0.
  function automatic logic [12:0] ref_lfsr(input logic [12:0] l);
    logic fb;
    fb = ^(l & 13'h100D);
    return 13'((l << 1) | 13'(fb));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int k, input string tag);
    check({tag, " pat"},  32'(pat[k]), 32'h0);
    check({tag, " sig"},  32'(sig[k]), 32'h0);
    check({tag, " cnt"},  32'(pat_cnt[k]), 32'h0);
    check({tag, " busy"}, 32'(busy[k]), 32'h0);
    check({tag, " done"}, 32'(done[k]), 32'h0);
    check({tag, " pass"}, 32'(pass[k]), 32'h0);
  endtask

  // mode 0: constant resp, 1: random resp, 2: gate model in the loop.
  task automatic do_run(input int k, input int mode, input logic [9:0] cval,
                        input int abort_at, input int rst_at, input bit poke_start,
                        output logic [9:0] sig_out);
    logic [12:0] l;
    logic [9:0]  m;
    logic [9:0]  r;
    int          p;
    p = pats_of(k);
    l = (seed_of(k) == 13'h0) ? 13'h0001 : seed_of(k);
    m = '0;
    pat_log.delete();
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    for (int c = 0; c < p; c++) begin
      check("run busy", 32'(busy[k]), 32'h1);
      check("run done", 32'(done[k]), 32'h0);
      check("run pat",  32'(pat[k]), 32'(l));
      check("run cnt",  32'(pat_cnt[k]), 32'(c));
      pat_log.push_back(pat[k]);
      r = (mode == 0) ? cval : (mode == 1) ? 10'($urandom) : gate_fn(l);
      if (k < 4) rsp[k] = r;
      if (poke_start) start[k] = ($urandom_range(0, 3) == 0);
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_zero(k, "async rst");
        start[k] = 1'b0;
        #3 rst_n = 1'b1;
        sig_out = '0;
        return;
      end
      if (c == abort_at) abort[k] = 1'b1;
      tick();
      start[k] = 1'b0;
      abort[k] = 1'b0;
      if (c == abort_at) begin
        check("abort busy", 32'(busy[k]), 32'h0);
        check("abort done", 32'(done[k]), 32'h0);
        check("abort pass", 32'(pass[k]), 32'h0);
        check("abort pat",  32'(pat[k]), 32'(l));
        check("abort sig",  32'(sig[k]), 32'(m));
        check("abort cnt",  32'(pat_cnt[k]), 32'(c));
        sig_out = m;
        return;
      end
      m = ref_misr(m, r);
      if (c + 1 < p) l = ref_lfsr(l);
    end
    for (int h = 0; h < 3; h++) begin
      check("end done", 32'(done[k]), 32'h1);
      check("end busy", 32'(busy[k]), 32'h0);
      check("end pat",  32'(pat[k]), 32'(l));
      check("end sig",  32'(sig[k]), 32'(m));
      check("end cnt",  32'(pat_cnt[k]), 32'(p));
      check("end pass", 32'(pass[k]), 32'(m == gold_of(k)));
      if (k < 4) rsp[k] = 10'($urandom);
      tick();
    end
    sig_out = m;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] s;
    logic [9:0] s_ref;
    int         ab;
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    for (int k = 0; k < 4; k++) rsp[k] = '0;
    #3;
    for (int k = 0; k < 5; k++) check_zero(k, "reset");
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) check_zero(k, "idle");

    // Zero response stub: pattern sequence and empty signature.
    do_run(0, 0, 10'h000, -1, -1, 1'b0, s);
    check("p4 len", 32'(pat_log.size()), 32'd4);
    if (pat_log.size() == 4) begin
      check("p4 pat0", 32'(pat_log[0]), 32'h0001);
      check("p4 pat1", 32'(pat_log[1]), 32'h0003);
      check("p4 pat2", 32'(pat_log[2]), 32'h0007);
      check("p4 pat3", 32'(pat_log[3]), 32'h000E);
    end
    check("p4 sig", 32'(sig[0]), 32'h000);

    // All-ones response, two golden values.
    do_run(1, 0, 10'h3FF, -1, -1, 1'b0, s);
    check("p2 sig g8", 32'(sig[1]), 32'h008);
    check("p2 pass g8", 32'(pass[1]), 32'h1);
    do_run(2, 0, 10'h3FF, -1, -1, 1'b0, s);
    check("p2 sig g0", 32'(sig[2]), 32'h008);
    check("p2 pass g0", 32'(pass[2]), 32'h0);

    // Zero seed, single pattern.
    do_run(3, 0, 10'h155, -1, -1, 1'b0, s);
    check("p1 seed", 32'(pat_log[0]), 32'h0001);
    check("p1 sig", 32'(sig[3]), 32'h155);

    // Abort from DONE, then start+abort together from IDLE.
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    check("done abort done", 32'(done[1]), 32'h0);
    check("done abort pass", 32'(pass[1]), 32'h0);
    check("done abort sig",  32'(sig[1]), 32'h008);
    check("done abort cnt",  32'(pat_cnt[1]), 32'd2);
    start[1] = 1'b1;
    abort[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    abort[1] = 1'b0;
    check("prio busy", 32'(busy[1]), 32'h0);
    check("prio done", 32'(done[1]), 32'h0);
    tick();
    check("prio idle", 32'(busy[1]), 32'h0);

    // Gate model in the loop, twice for determinism.
    do_run(4, 2, '0, -1, -1, 1'b0, s_ref);
    do_run(4, 2, '0, -1, -1, 1'b1, s);
    check("determinism", 32'(sig[4]), 32'(s_ref));

    // Abort at pattern 5, then a clean restart.
    do_run(4, 2, '0, 5, -1, 1'b0, s);
    tick();
    check("post abort idle", 32'(busy[4]), 32'h0);
    do_run(4, 2, '0, -1, -1, 1'b0, s);
    check("restart sig", 32'(sig[4]), 32'(s_ref));

    // Random responses with random abort points and ignored starts.
    for (int i = 0; i < 6; i++) begin
      ab = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : -1;
      do_run(0, 1, '0, ab, -1, 1'b1, s);
      do_run(1, 1, '0, -1, -1, 1'b1, s);
    end

    // Asynchronous reset mid-run.
    do_run(4, 2, '0, -1, $urandom_range(3, 200), 1'b1, s);
    for (int h = 0; h < 4; h++) begin
      tick();
      check_zero(4, "post rst");
    end
    do_run(4, 2, '0, -1, -1, 1'b1, s);
    check("post rst sig", 32'(sig[4]), 32'(s_ref));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
